// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback entry record.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO; per-slot valid bits double as the occupancy view
// used by the busy scoreboard.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [WIDTH-1:0]            wdata_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [WIDTH-1:0]            head_o,
  output logic [DEPTH-1:0]            ent_vld_o,
  output logic [DEPTH-1:0][WIDTH-1:0] ent_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [PW-1:0]               rd_q, wr_q;
  logic                        do_push, do_pop;

  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    vld_d = vld_q;
    if (do_pop)  vld_d[rd_q] = 1'b0;
    if (do_push) vld_d[wr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else begin
      vld_q <= vld_d;
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign head_o    = mem_q[rd_q];
  assign ent_vld_o = vld_q;
  assign ent_o     = mem_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port among NUM_REQ queued
// writeback requesters, with a busy scoreboard of in-flight destinations.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int ADDR_W     = regfile_pkg::ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        reg_write,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [1:0]                  grant_id,
  output logic [regfile_pkg::NUM_REGS-1:0] busy
);
  import regfile_pkg::*;

  localparam int EW = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [NUM_REQ-1:0]                            full, empty, pop;
  logic [NUM_REQ-1:0][EW-1:0]                    head;
  logic [NUM_REQ-1:0][FIFO_DEPTH-1:0]            ent_vld;
  logic [NUM_REQ-1:0][FIFO_DEPTH-1:0][EW-1:0]    ent;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (req_valid[gi]),
      .pop_i     (pop[gi]),
      .wdata_i   ({req_addr[gi*ADDR_W +: ADDR_W], req_data[gi*DATA_W +: DATA_W]}),
      .full_o    (full[gi]),
      .empty_o   (empty[gi]),
      .head_o    (head[gi]),
      .ent_vld_o (ent_vld[gi]),
      .ent_o     (ent[gi])
    );
  end

  assign req_ready = ~full;

  // ptr_q is the first requester considered this cycle (last_grant + 1).
  logic [1:0] ptr_q, ptr_d, win;
  logic       gnt;
  entry_t     win_ent;

  always_comb begin
    gnt     = 1'b0;
    win     = '0;
    win_ent = '0;
    pop     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt && !empty[j] && j >= int'(ptr_q)) begin
        gnt = 1'b1; win = 2'(j); win_ent = entry_t'(head[j]); pop[j] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt && !empty[j] && j < int'(ptr_q)) begin
        gnt = 1'b1; win = 2'(j); win_ent = entry_t'(head[j]); pop[j] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (gnt) ptr_d = (int'(win) == NUM_REQ - 1) ? 2'd0 : win + 2'd1;
  end

  logic              reg_write_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [1:0]        grant_id_q;

  // x0 heads still consume a grant and update the data path, but never write.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      grant_id_q  <= '0;
      ptr_q       <= '0;
    end else begin
      reg_write_q <= gnt && (win_ent.addr != '0);
      ptr_q       <= ptr_d;
      if (gnt) begin
        wr_addr_q  <= win_ent.addr;
        wr_data_q  <= win_ent.data;
        grant_id_q <= win;
      end
    end
  end

  assign reg_write = reg_write_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign grant_id  = grant_id_q;

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (ent_vld[i][j]) busy[ent[i][j][EW-1 -: ADDR_W]] = 1'b1;
      end
    end
    if (reg_write_q) busy[wr_addr_q] = 1'b1;
    busy[0] = 1'b0;
  end
endmodule
